// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-ported memory bank between
// the instruction-fetch port (read-only) and the data port (loads/stores).
// Round-robin arbitration, IDLE -> ACCESS -> RESP sequencing, one-cycle
// acknowledge pulse per completed access. Port index 0 = fetch, 1 = data.
module mem_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Grant encoding doubles as the port index.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t             state_reg, state_next;
    logic               last_grant_reg, last_grant_next;
    logic               winner_reg, winner_next;
    logic               oor_reg, oor_next;       // latched out-of-range flag
    logic               acc_we_reg, acc_we_next; // latched store flag
    logic               mem_en_reg, mem_en_next;
    logic               mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]  mem_wdata_reg, mem_wdata_next;

    logic               resp_done;
    logic [1:0]         port_req;
    logic [1:0]         eligible;
    logic [1:0]         ack_vec;
    logic [1:0]         err_vec;
    logic [DATA_W-1:0]  rdata_vec [2];

    logic               grant_valid;
    logic               grant_port;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_we;
    logic               sel_in_range;

    assign port_req  = {d_req, if_req};
    assign resp_done = (state_reg == RESP);

    // Per-port response registers; a port is ineligible during its own ack cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);
            logic              ack_q;
            logic              err_q;
            logic [DATA_W-1:0] rdata_q;
            logic              hit;

            assign hit = resp_done && (winner_reg == PORT_ID);

            // Ack/err pulse on the edge ending RESP; rdata only for in-range loads.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    ack_q <= hit;
                    err_q <= hit && oor_reg;
                    if (hit && !oor_reg && !acc_we_reg) begin
                        rdata_q <= mem_rdata;
                    end
                end
            end

            assign ack_vec[gi]   = ack_q;
            assign err_vec[gi]   = err_q;
            assign rdata_vec[gi] = rdata_q;
            assign eligible[gi]  = port_req[gi] & ~ack_q;
        end
    endgenerate

    // Arbitration, next-state and memory-command selection.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        winner_next     = winner_reg;
        oor_next        = oor_reg;
        acc_we_next     = acc_we_reg;
        mem_en_next     = mem_en_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;

        grant_valid = |eligible;
        if (eligible == 2'b11) begin
            grant_port = ~last_grant_reg;
        end else begin
            grant_port = eligible[PORT_D];
        end
        sel_addr     = (grant_port == PORT_D) ? d_addr : if_addr;
        sel_we       = (grant_port == PORT_D) && d_we;
        sel_in_range = (32'(sel_addr) < DEPTH_W);

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next      = ACCESS;
                    last_grant_next = grant_port;
                    winner_next     = grant_port;
                    oor_next        = ~sel_in_range;
                    acc_we_next     = sel_we;
                    mem_en_next     = sel_in_range;
                    mem_we_next     = sel_we && sel_in_range;
                    mem_addr_next   = sel_addr;
                    mem_wdata_next  = (grant_port == PORT_D) ? d_wdata : '0;
                end
            end
            ACCESS: begin
                state_next  = RESP;
                mem_en_next = 1'b0;
                mem_we_next = 1'b0;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, grant history and registered memory command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= PORT_D;
            winner_reg     <= PORT_IF;
            oor_reg        <= 1'b0;
            acc_we_reg     <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            winner_reg     <= winner_next;
            oor_reg        <= oor_next;
            acc_we_reg     <= acc_we_next;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
        end
    end

    assign if_ack    = ack_vec[PORT_IF];
    assign if_err    = err_vec[PORT_IF];
    assign if_rdata  = rdata_vec[PORT_IF];
    assign d_ack     = ack_vec[PORT_D];
    assign d_err     = err_vec[PORT_D];
    assign d_rdata   = rdata_vec[PORT_D];
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (DEPTH = 16 so that out-of-range
// addresses are reachable). Stimulus pushes expected acks; a negedge monitor
// pops and compares whenever an ack is presented.
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory bank (not reset); contents preset on first edge.
    logic [DW-1:0] mem [32];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0100 + 32'(i);
            mem[3] = 32'hDEAD_BEEF;
            mem_init = 1'b1;
        end
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    typedef struct {
        logic          port;   // 0 = fetch, 1 = data
        logic          err;
        logic [DW-1:0] if_rd;
        logic [DW-1:0] d_rd;
        int            ack_cyc;
    } exp_t;

    exp_t sb[$];
    int   en_log[$];
    int   checks = 0;
    int   failures = 0;
    int   we_cnt = 0;
    int   last_en_cyc = -100;
    exp_t e;
    logic [DW-1:0] m_if = '0;
    logic [DW-1:0] m_d = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Monitor: ack scoreboard plus memory-strobe rules every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_ack || d_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'({if_ack, d_ack}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("ack port=%s cycle=%0d if_rdata=%08h d_rdata=%08h if_err=%0b d_err=%0b",
                             e.port ? "data" : "fetch", cyc, if_rdata, d_rdata, if_err, d_err);
                    chk("ack_port", 32'({if_ack, d_ack}), e.port ? 32'd1 : 32'd2);
                    chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                    chk("ack_err", 32'(e.port ? d_err : if_err), 32'(e.err));
                    chk("if_rdata", if_rdata, e.if_rd);
                    chk("d_rdata", d_rdata, e.d_rd);
                end
            end
            if (mem_en) begin
                en_log.push_back(cyc);
                chk("en_gap_ge3", 32'(cyc - last_en_cyc >= 3), 32'd1);
                chk("en_addr_in_range", 32'(mem_addr < AW'(DP)), 32'd1);
                last_en_cyc = cyc;
            end
            chk("we_implies_en", 32'(mem_we & ~mem_en), 32'd0);
            if (mem_we) we_cnt++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_if_ack"}, 32'(if_ack), 32'd0);
        chk({tag, "_d_ack"}, 32'(d_ack), 32'd0);
        chk({tag, "_if_err"}, 32'(if_err), 32'd0);
        chk({tag, "_d_err"}, 32'(d_err), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        m_if = '0;
        m_d = '0;
    endtask

    // One request issued in an IDLE cycle T; ack is required in T+3.
    task automatic do_req(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic exp_err,
                          input logic [DW-1:0] exp_rd);
        exp_t n;
        int   k;
        logic got;
        @(negedge clk);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        if (!exp_err && !we) begin
            if (port) m_d = exp_rd; else m_if = exp_rd;
        end
        n.port = port; n.err = exp_err; n.if_rd = m_if; n.d_rd = m_d; n.ack_cyc = cyc + 3;
        sb.push_back(n);
        @(negedge clk);
        chk("access_mem_en", 32'(mem_en), 32'(!exp_err));
        chk("access_mem_we", 32'(mem_we), 32'(we && !exp_err));
        chk("access_mem_addr", 32'(mem_addr), 32'(addr));
        if (we) chk("access_mem_wdata", mem_wdata, wdata);
        got = 1'b0;
        k = 0;
        while (!got && k < 10) begin
            if (port ? d_ack : if_ack) got = 1'b1;
            else begin @(negedge clk); k++; end
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (port) d_req = 1'b0; else if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, en0, we0, acks, n;
        exp_t x;

        do_reset();

        // Single fetch, boundary in-range fetch, store then load.
        do_req(1'b0, 1'b0, 5'd3, 32'd0, 1'b0, 32'hDEAD_BEEF);
        do_req(1'b0, 1'b0, 5'd15, 32'd0, 1'b0, 32'h0000_010F);
        we0 = we_cnt;
        do_req(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 32'd0);
        chk("store_we_cycles", 32'(we_cnt - we0), 32'd1);
        do_req(1'b1, 1'b0, 5'd5, 32'd0, 1'b0, 32'h0000_1234);

        // Out-of-range load, store and fetch (16 is the first bad address).
        we0 = we_cnt;
        do_req(1'b1, 1'b0, 5'd31, 32'd0, 1'b1, 32'd0);
        do_req(1'b1, 1'b1, 5'd20, 32'h0000_0BAD, 1'b1, 32'd0);
        do_req(1'b0, 1'b0, 5'd16, 32'd0, 1'b1, 32'd0);
        chk("oor_we_cycles", 32'(we_cnt - we0), 32'd0);

        // Single requester held high: one access every 4 cycles.
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 5'd3;
        m_if = 32'hDEAD_BEEF;
        t = cyc;
        en0 = en_log.size();
        for (int k = 0; k < 3; k++) begin
            x.port = 1'b0; x.err = 1'b0; x.if_rd = m_if; x.d_rd = m_d; x.ack_cyc = t + 3 + 4 * k;
            sb.push_back(x);
        end
        acks = 0;
        n = 0;
        while (acks < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (if_ack) acks++;
        end
        if_req = 1'b0;
        chk("excl_ack_count", 32'(acks), 32'd3);
        chk("excl_en_count", 32'(en_log.size() - en0), 32'd3);
        if (en_log.size() >= en0 + 3) begin
            chk("excl_en_spacing0", 32'(en_log[en0 + 1] - en_log[en0]), 32'd4);
            chk("excl_en_spacing1", 32'(en_log[en0 + 2] - en_log[en0 + 1]), 32'd4);
        end

        // Reset during ACCESS of a fetch: no ack ever, outputs cleared.
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 5'd3;
        @(negedge clk);
        chk("midreset_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        m_if = '0;
        m_d = '0;
        repeat (6) @(negedge clk);
        do_req(1'b0, 1'b0, 5'd3, 32'd0, 1'b0, 32'hDEAD_BEEF);

        // Tie from reset: fetch, data, fetch, data, acks 3 cycles apart.
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 5'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5;
        t = cyc;
        x.err = 1'b0;
        x.port = 1'b0; x.if_rd = 32'hDEAD_BEEF; x.d_rd = 32'd0;        x.ack_cyc = t + 3;  sb.push_back(x);
        x.port = 1'b1; x.if_rd = 32'hDEAD_BEEF; x.d_rd = 32'h0000_1234; x.ack_cyc = t + 6;  sb.push_back(x);
        x.port = 1'b0;                                                   x.ack_cyc = t + 9;  sb.push_back(x);
        x.port = 1'b1;                                                   x.ack_cyc = t + 12; sb.push_back(x);
        acks = 0;
        n = 0;
        while (acks < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (if_ack || d_ack) acks++;
        end
        if_req = 1'b0;
        d_req = 1'b0;
        chk("tie_ack_count", 32'(acks), 32'd4);

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
